fp_normalize_stage: RTL and testbench

- Pipelined normalization stage of the bfloat16-style adder datapath (1 sign, 8 exponent, 7 fraction bits).
- Sits directly downstream of the 9-bit leading-one detector. Consumes the raw 9-bit mantissa sum and the detector's signed 5-bit index.
- Shifts the mantissa so the hidden bit lands at bit 7 and adjusts the exponent. Flushes to zero or saturates to infinity on range exits.
- Two-stage valid/ready pipeline with full backpressure.

---
 rtl/fp_normalize_stage.sv | 186 ++++++++++++++++++
 tb/tb_fp_normalize_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_stage.sv
// Two-stage normalization of a bfloat16-style adder result: realigns the raw
// mantissa sum on the detected leading one, adjusts the exponent, flushes or saturates.
module fp_normalize_stage #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic [FRAC_W+1:0]         in_mant,
  input  logic signed [4:0]         in_lead_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_word,
  output logic                      out_uf,
  output logic                      out_of
);

  localparam int MANT_W = FRAC_W + 2;
  localparam int ALGN_W = FRAC_W + 1;
  localparam int WORD_W = 1 + EXP_W + FRAC_W;
  localparam int XW     = EXP_W + 2;
  localparam int SH_W   = $clog2(FRAC_W + 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_RSH  = 2'd1,
    ACT_LSH  = 2'd2,
    ACT_ZERO = 2'd3
  } act_e;

  typedef struct packed {
    act_e            act;
    logic [SH_W-1:0] sh;
  } dec_t;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              uf;
    logic              of;
  } res_t;

  function automatic dec_t decode_idx(input logic signed [4:0] idx);
    dec_t d;
    int   i;
    i     = idx;
    d.act = ACT_ZERO;
    d.sh  = '0;
    if (i == FRAC_W + 1) begin
      d.act = ACT_RSH;
    end else if (i == FRAC_W) begin
      d.act = ACT_NONE;
    end else if (i >= 0 && i < FRAC_W) begin
      d.act = ACT_LSH;
      d.sh  = SH_W'(FRAC_W - i);
    end
    return d;
  endfunction

  // The one-bit right shift is applied up front so stage 2 only ever shifts left;
  // the dropped LSB is truncated, never rounded.
  function automatic logic [ALGN_W-1:0] pre_align(input logic [MANT_W-1:0] m, input act_e a);
    if (a == ACT_RSH) return m[MANT_W-1:1];
    return m[ALGN_W-1:0];
  endfunction

  function automatic res_t finalize(input logic              s,
                                    input logic [EXP_W-1:0]  e,
                                    input logic [ALGN_W-1:0] m,
                                    input act_e              a,
                                    input logic [SH_W-1:0]   sh);
    res_t                   r;
    logic signed [XW-1:0]   adj;
    logic [FRAC_W-1:0]      frac;
    adj = $signed({2'b00, e});
    case (a)
      ACT_RSH: adj = adj + $signed(XW'(1));
      ACT_LSH: adj = adj - $signed(XW'(sh));
      default: adj = adj;
    endcase
    frac = FRAC_W'(m << sh);
    r.word = {s, adj[EXP_W-1:0], frac};
    r.uf   = 1'b0;
    r.of   = 1'b0;
    if (a == ACT_ZERO) begin
      r.word = {s, {(EXP_W+FRAC_W){1'b0}}};
    end else if (adj <= $signed(XW'(0))) begin
      r.word = {s, {(EXP_W+FRAC_W){1'b0}}};
      r.uf   = 1'b1;
    end else if (adj >= EXP_MAX) begin
      r.word = {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      r.of   = 1'b1;
    end
    return r;
  endfunction

  logic              vld_p1_q, vld_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic              p2_free, in_fire, p1_fire;

  logic              sign_p1_q, sign_p1_d;
  logic [EXP_W-1:0]  exp_p1_q,  exp_p1_d;
  logic [ALGN_W-1:0] mant_p1_q, mant_p1_d;
  act_e              act_p1_q,  act_p1_d;
  logic [SH_W-1:0]   sh_p1_q,   sh_p1_d;

  logic [WORD_W-1:0] word_p2_q, word_p2_d;
  logic              uf_p2_q,   uf_p2_d;
  logic              of_p2_q,   of_p2_d;

  dec_t              dec_in;
  res_t              res_p1;

  always_comb begin
    p2_free  = !vld_p2_q || out_ready;
    in_ready = !vld_p1_q || p2_free;
    in_fire  = in_valid && in_ready;
    p1_fire  = vld_p1_q && p2_free;
    vld_p1_d = in_ready ? in_valid : vld_p1_q;
    vld_p2_d = p2_free ? vld_p1_q : vld_p2_q;
  end

  // Stage 1: decode the leading-one index into a shift action
  always_comb begin
    dec_in    = decode_idx(in_lead_idx);
    sign_p1_d = sign_p1_q;
    exp_p1_d  = exp_p1_q;
    mant_p1_d = mant_p1_q;
    act_p1_d  = act_p1_q;
    sh_p1_d   = sh_p1_q;
    if (in_fire) begin
      sign_p1_d = in_sign;
      exp_p1_d  = in_exp;
      mant_p1_d = pre_align(in_mant, dec_in.act);
      act_p1_d  = dec_in.act;
      sh_p1_d   = dec_in.sh;
    end
  end

  always_ff @(posedge clk) begin
    sign_p1_q <= sign_p1_d;
    exp_p1_q  <= exp_p1_d;
    mant_p1_q <= mant_p1_d;
    act_p1_q  <= act_p1_d;
    sh_p1_q   <= sh_p1_d;
  end

  // Stage 2: exponent adjust, range checks and packing
  always_comb begin
    res_p1    = finalize(sign_p1_q, exp_p1_q, mant_p1_q, act_p1_q, sh_p1_q);
    word_p2_d = word_p2_q;
    uf_p2_d   = uf_p2_q;
    of_p2_d   = of_p2_q;
    if (p1_fire) begin
      word_p2_d = res_p1.word;
      uf_p2_d   = res_p1.uf;
      of_p2_d   = res_p1.of;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      word_p2_q <= '0;
      uf_p2_q   <= 1'b0;
      of_p2_q   <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      word_p2_q <= word_p2_d;
      uf_p2_q   <= uf_p2_d;
      of_p2_q   <= of_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_word  = word_p2_q;
  assign out_uf    = uf_p2_q;
  assign out_of    = of_p2_q;

endmodule

// File: tb/tb_fp_normalize_stage.sv
// Scoreboard bench for fp_normalize_stage: directed vectors push expected words,
// an independent monitor pops and compares on every output handshake.
module tb_fp_normalize_stage;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_sign = 1'b0;
  logic [7:0]        in_exp = '0;
  logic [8:0]        in_mant = '0;
  logic signed [4:0] in_lead_idx = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [15:0]       out_word;
  logic              out_uf;
  logic              out_of;

  fp_normalize_stage #(.EXP_W(8), .FRAC_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_lead_idx(in_lead_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_uf(out_uf), .out_of(out_of)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    logic        uf;
    logic        of;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_t;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          accepted = 0;
  bit          chk_lat = 1'b1;
  bit          held = 1'b0;
  logic [15:0] held_w;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (in_valid)
      assert (in_lead_idx >= -5'sd1 && in_lead_idx <= 5'sd8)
        else $error("illegal lead index %0d", in_lead_idx);

  function automatic logic [15:0] mk(input logic s, input logic [7:0] e, input logic [6:0] f);
    return {s, e, f};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Call at a falling edge; returns at the falling edge after the word is taken.
  task automatic send(input logic s, input logic [7:0] e, input logic [8:0] m,
                      input int idx, input logic [15:0] ew, input logic euf, input logic eof);
    exp_t t;
    bit   acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    in_sign = s; in_exp = e; in_mant = m; in_lead_idx = 5'(idx); in_valid = 1'b1;
    while (!acc && n < 200) begin
      #1;
      if (in_ready && rst_n) begin
        acc = 1'b1;
        t.w = ew; t.uf = euf; t.of = eof; t.acc = cyc; t.lat = chk_lat;
        sb.push_back(t);
        accepted++;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor samples shortly before the rising edge, once inputs have settled.
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      held = 1'b0;
    end else if (out_valid) begin
      if (held) check("hold_stable", 32'(out_word), 32'(held_w));
      if (out_ready) begin
        held = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h want no word", out_word);
        end else begin
          mon_t = sb.pop_front();
          check("word", 32'(out_word), 32'(mon_t.w));
          check("uf", 32'(out_uf), 32'(mon_t.uf));
          check("of", 32'(out_of), 32'(mon_t.of));
          if (mon_t.lat) check("latency", 32'(cyc - mon_t.acc), 32'd2);
        end
      end else begin
        held   = 1'b1;
        held_w = out_word;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_word", 32'(out_word), 32'd0);
    check("rst_out_uf", 32'(out_uf), 32'd0);
    check("rst_out_of", 32'(out_of), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Back-to-back directed vectors at full rate
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    send(0, 8'd10,  9'h100,  8, mk(0, 8'd11,  7'h00), 0, 0);
    send(0, 8'd20,  9'h0C0,  7, mk(0, 8'd20,  7'h40), 0, 0);
    send(0, 8'd20,  9'h003,  1, mk(0, 8'd14,  7'h40), 0, 0);
    send(1, 8'd77,  9'h000, -1, mk(1, 8'd0,   7'h00), 0, 0);
    send(0, 8'd3,   9'h001,  0, mk(0, 8'd0,   7'h00), 1, 0);
    send(0, 8'd254, 9'h180,  8, mk(0, 8'd255, 7'h00), 0, 1);
    send(0, 8'd253, 9'h180,  8, mk(0, 8'd254, 7'h40), 0, 0);
    send(1, 8'd100, 9'h050,  6, mk(1, 8'd99,  7'h20), 0, 0);
    send(0, 8'd10,  9'h1FF,  8, mk(0, 8'd11,  7'h7F), 0, 0);
    send(0, 8'd1,   9'h040,  6, mk(0, 8'd0,   7'h00), 1, 0);
    send(0, 8'd255, 9'h085,  7, mk(0, 8'd255, 7'h00), 0, 1);
    send(1, 8'd1,   9'h080,  7, mk(1, 8'd1,   7'h00), 0, 0);
    send(1, 8'd200, 9'h001,  0, mk(1, 8'd193, 7'h00), 0, 0);
    wait_drain();

    // Backpressure: four words against a stalled output
    out_ready = 1'b0;
    chk_lat   = 1'b0;
    accepted  = 0;
    fork
      begin
        send(0, 8'd50, 9'h0C0, 7, mk(0, 8'd50, 7'h40), 0, 0);
        send(1, 8'd60, 9'h100, 8, mk(1, 8'd61, 7'h00), 0, 0);
        send(0, 8'd70, 9'h003, 1, mk(0, 8'd64, 7'h40), 0, 0);
        send(1, 8'd80, 9'h0A0, 7, mk(1, 8'd80, 7'h20), 0, 0);
      end
    join_none
    repeat (5) @(negedge clk);
    #1;
    check("bp_accepted", 32'(accepted), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    wait fork;
    wait_drain();
    check("bp_total", 32'(accepted), 32'd4);

    // Reset with two words in flight
    @(negedge clk);
    out_ready = 1'b0;
    chk_lat   = 1'b1;
    send(0, 8'd30, 9'h0C0, 7, mk(0, 8'd30, 7'h40), 0, 0);
    send(1, 8'd40, 9'h100, 8, mk(1, 8'd41, 7'h00), 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_word", 32'(out_word), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    send(0, 8'd90, 9'h003, 1, mk(0, 8'd84, 7'h40), 0, 0);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
